mux_2to1_reg: RTL and testbench
===============================

// Module: mux_2to1_reg
// PURPOSE
//  Registered 2-to-1 multiplexer with a complementary output.
//  SEL picks one of two data words, A or B. The chosen word is captured on the
//  rising clock edge and driven as OUTPUT; its bitwise inverse is driven as OUTPUT_BAR.
//  General-purpose select stage for datapaths that need a true/complement pair.
// PARAMETERS
//  WIDTH  1  data width in bits of A, B, OUTPUT and OUTPUT_BAR (legal range >= 1)
// PORTS
//  CLK         in   1      clock; the only clock, rising-edge active
//  RST_N       in   1      reset; asynchronous, active-low
//  A           in   WIDTH  data input selected when SEL=0
//  B           in   WIDTH  data input selected when SEL=1
//  SEL         in   1      select: 0 -> A, 1 -> B
//  OUTPUT      out  WIDTH  registered selected data
//  OUTPUT_BAR  out  WIDTH  bitwise complement of OUTPUT
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Asserting RST_N=0:
//    - OUTPUT goes to all-0s immediately, without waiting for a clock edge.
//    - OUTPUT_BAR goes to all-1s.
//    - Both hold these values for as long as RST_N=0.
//  - Releasing reset: RST_N is released synchronously to CLK. The first rising edge
//    with RST_N=1 loads data normally.
//  - Each rising CLK edge with RST_N=1:
//    OUTPUT <= SEL ? B : A
//  - Latency: 1 cycle from A, B and SEL to OUTPUT.
//  - Handshake: none. The register loads on every edge; there is no enable and no stall.
//  - OUTPUT_BAR equals ~OUTPUT at all times, including during reset.
//    - It is derived from the same register, never from a separate register.
//    - OUTPUT and OUTPUT_BAR therefore change on the same edge.
//  - Arithmetic: none. Operation is bitwise and width-preserving; no truncation or extension.
//  - SEL changing in the same cycle as the data: the values of SEL, A and B sampled
//    together at the edge decide the result.
//  - Reset asserted mid-operation: a captured value is lost. OUTPUT goes to 0 and no
//    stale value reappears after release.
//  - No state machine. The only state is the WIDTH-bit output register.
//  - X/Z on SEL must not be masked (no default-to-A). X propagates to OUTPUT in
//    simulation so the bench can detect it.
//  - Synthesizable, no latches, no combinational path from inputs to outputs.
// TESTING
//  - Reset: hold RST_N=0 with random A/B/SEL and toggle CLK -> OUTPUT=0, OUTPUT_BAR=1
//    throughout. Also assert RST_N=0 between clock edges -> outputs clear before the
//    next edge.
//  - Select A: WIDTH=1, SEL=0, A=1, B=0, one edge -> OUTPUT=1, OUTPUT_BAR=0.
//  - Select B: SEL=1, A=0, B=1, one edge -> OUTPUT=1, OUTPUT_BAR=0.
//  - Unselected input ignored, part 1: SEL=0, A=0, B=1 -> OUTPUT=0, OUTPUT_BAR=1.
//  - Unselected input ignored, part 2: SEL=1, A=1, B=0 -> OUTPUT=0, OUTPUT_BAR=1.
//  - Latency and width, WIDTH=8:
//    - A=8'hA5, B=8'h3C, SEL toggled every cycle.
//    - OUTPUT follows A/B one cycle later: 8'hA5, 8'h3C, ...
//    - OUTPUT_BAR shows the complements: 8'h5A, 8'hC3.
//    - Check OUTPUT_BAR == ~OUTPUT on every cycle.

Source files
------------

// File: rtl/mux_2to1_reg.sv
// mux_2to1_reg: registered 2-to-1 select with a true/complement output pair
module mux_2to1_reg #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SEL,
    output logic [WIDTH-1:0] OUTPUT,
    output logic [WIDTH-1:0] OUTPUT_BAR
);
    logic [WIDTH-1:0] out_d, out_q;
    always_comb begin
        out_d = SEL ? B : A;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) out_q <= '0;
        else        out_q <= out_d;
    end
    // Complement comes off the same register so the pair can never skew
    assign OUTPUT     = out_q;
    assign OUTPUT_BAR = ~out_q;
endmodule

// File: tb/tb_mux_2to1_reg.sv
// tb_mux_2to1_reg: directed checks of the registered mux at WIDTH=1 and WIDTH=8
module tb_mux_2to1_reg;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       sel = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       out1, bar1;
    logic [7:0] out8, bar8;
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    mux_2to1_reg #(.WIDTH(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .A(a1), .B(b1), .SEL(sel),
        .OUTPUT(out1), .OUTPUT_BAR(bar1)
    );
    mux_2to1_reg #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .A(a8), .B(b8), .SEL(sel),
        .OUTPUT(out8), .OUTPUT_BAR(bar8)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp1, input logic [7:0] exp8);
        chk({tag, "_out1"}, {7'b0, out1}, {7'b0, exp1});
        chk({tag, "_bar1"}, {7'b0, bar1}, {7'b0, ~exp1});
        chk({tag, "_out8"}, out8, exp8);
        chk({tag, "_bar8"}, bar8, ~exp8);
    endtask

    task automatic step(input logic s, input logic ia1, input logic ib1,
                        input logic [7:0] ia8, input logic [7:0] ib8);
        @(negedge CLK);
        sel = s; a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset held with random inputs across several edges
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            chk_all("reset_hold", 1'b0, 8'h00);
        end
        @(negedge CLK);
        RST_N = 1'b1;

        step(1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C);
        chk_all("sel_a", 1'b1, 8'hA5);
        step(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C);
        chk_all("sel_b", 1'b1, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h0F, 8'hF0);
        chk_all("ignore_b", 1'b0, 8'h0F);
        step(1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0);
        chk_all("ignore_a", 1'b0, 8'hF0);

        // SEL toggles every cycle: output lags by one edge
        step(1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C);
        chk_all("tog0", 1'b1, 8'hA5);
        step(1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C);
        chk_all("tog1", 1'b0, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C);
        chk_all("tog2", 1'b1, 8'hA5);
        step(1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C);
        chk_all("tog3", 1'b0, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C);
        chk_all("pre_async", 1'b1, 8'hA5);

        // Asynchronous reset between edges clears before the next edge
        #2;
        RST_N = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 8'h00);
        @(posedge CLK);
        #1;
        chk_all("async_hold", 1'b0, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk_all("release_no_stale", 1'b0, 8'h00);

        step(1'b1, 1'b0, 1'b1, 8'h11, 8'h7E);
        chk_all("post_release", 1'b1, 8'h7E);
        step(1'b0, 1'b0, 1'b1, 8'h81, 8'h7E);
        chk_all("post_release2", 1'b0, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
